// File: rtl/dfr_pkg.sv
// Shared types and helpers for the DFR matrix-multiply stage.
package dfr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MAC   = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Accumulator width: full product plus growth for K terms plus one guard bit.
    function automatic int acc_width(input int data_width, input int k);
        return 2 * data_width + $clog2(k) + 1;
    endfunction

endpackage

// File: rtl/dfr_mac_sat.sv
// Signed multiply-accumulate with synchronous clear and a shift/saturate output stage.
module dfr_mac_sat #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 68,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    shifted;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst || clear) acc <= '0;
        else if (en)      acc <= acc + prod_ext;
    end

    // Arithmetic shift truncates toward -inf; no rounding.
    assign shifted = acc >>> FRAC_BITS;

    always_comb begin
        result = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX)      result = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN) result = SAT_MIN[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/dfr_matrix_multiply.sv
// DFR matrix-multiply stage: Z = X * Y over three 1-cycle-latency RAMs.
module dfr_matrix_multiply
    import dfr_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int X_ROWS        = 5,
    parameter int Y_COLS        = 5,
    parameter int X_COLS_Y_ROWS = 5,
    parameter int FRAC_BITS     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] x_ram_addr,
    input  logic [DATA_WIDTH-1:0] x_ram_data,
    output logic [ADDR_WIDTH-1:0] y_ram_addr,
    input  logic [DATA_WIDTH-1:0] y_ram_data,
    output logic [ADDR_WIDTH-1:0] z_ram_addr,
    output logic [DATA_WIDTH-1:0] z_ram_data,
    output logic                  z_ram_we
);

    localparam int K  = X_COLS_Y_ROWS;
    localparam int AW = acc_width(DATA_WIDTH, K);

    state_t state, next_state;
    logic [ADDR_WIDTH-1:0] i, j, k;
    logic [ADDR_WIDTH-1:0] x_row, x_addr, y_addr, z_addr;
    logic last_k, last_col, last_elem;
    logic mac_en, mac_clear;

    assign last_k    = (k == ADDR_WIDTH'(K - 1));
    assign last_col  = (j == ADDR_WIDTH'(Y_COLS - 1));
    assign last_elem = last_col && (i == ADDR_WIDTH'(X_ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   next_state = MAC;
            MAC:     next_state = last_k ? WRITE : FETCH;
            WRITE:   next_state = last_elem ? IDLE : FETCH;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        z_ram_we  = (state == WRITE);
        mac_clear = (state == WRITE);
        mac_en    = (state == MAC);
    end

    // Address counters only step by 1, K or Y_COLS so the address path needs no multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            x_row  <= '0;
            x_addr <= '0;
            y_addr <= '0;
            z_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) busy <= 1'b1;
                MAC: if (!last_k) begin
                    k      <= k + 1'b1;
                    x_addr <= x_addr + 1'b1;
                    y_addr <= y_addr + ADDR_WIDTH'(Y_COLS);
                end
                WRITE: begin
                    k <= '0;
                    if (last_elem) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        i      <= '0;
                        j      <= '0;
                        x_row  <= '0;
                        x_addr <= '0;
                        y_addr <= '0;
                        z_addr <= '0;
                    end else begin
                        z_addr <= z_addr + 1'b1;
                        if (last_col) begin
                            i      <= i + 1'b1;
                            j      <= '0;
                            x_row  <= x_row + ADDR_WIDTH'(K);
                            x_addr <= x_row + ADDR_WIDTH'(K);
                            y_addr <= '0;
                        end else begin
                            j      <= j + 1'b1;
                            x_addr <= x_row;
                            y_addr <= j + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_ram_addr = x_addr;
    assign y_ram_addr = y_addr;
    assign z_ram_addr = z_addr;

    dfr_mac_sat #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (AW),
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (mac_clear),
        .en    (mac_en),
        .a     (x_ram_data),
        .b     (y_ram_data),
        .result(z_ram_data)
    );

endmodule

// File: tb/tb_dfr_matrix_multiply.sv
// Directed bench: a default 5x5x5 instance and a 2x2x2 instance, each with behavioural RAMs.
module tb_dfr_matrix_multiply;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // default 5x5x5 instance
    logic        d_start, d_busy, d_done, d_we;
    logic [31:0] d_xa, d_ya, d_za, d_xd, d_yd, d_zd;
    logic [31:0] d_xm [32];
    logic [31:0] d_ym [32];
    logic [31:0] d_zm [32];
    int d_we_n = 0;
    int d_done_n = 0;

    // 2x2x2 instance
    logic        s_start, s_busy, s_done, s_we;
    logic [31:0] s_xa, s_ya, s_za, s_xd, s_yd, s_zd;
    logic [31:0] s_xm [32];
    logic [31:0] s_ym [32];
    logic [31:0] s_zm [32];
    logic [31:0] s_wlog [64];
    int s_we_n = 0;
    int s_done_n = 0;

    dfr_matrix_multiply dut (
        .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .done(d_done),
        .x_ram_addr(d_xa), .x_ram_data(d_xd), .y_ram_addr(d_ya), .y_ram_data(d_yd),
        .z_ram_addr(d_za), .z_ram_data(d_zd), .z_ram_we(d_we)
    );

    dfr_matrix_multiply #(
        .X_ROWS(2), .Y_COLS(2), .X_COLS_Y_ROWS(2)
    ) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .x_ram_addr(s_xa), .x_ram_data(s_xd), .y_ram_addr(s_ya), .y_ram_data(s_yd),
        .z_ram_addr(s_za), .z_ram_data(s_zd), .z_ram_we(s_we)
    );

    always @(posedge clk) begin
        d_xd <= d_xm[d_xa[4:0]];
        d_yd <= d_ym[d_ya[4:0]];
        if (d_we) begin
            d_zm[d_za[4:0]] <= d_zd;
            d_we_n <= d_we_n + 1;
        end
        if (d_done) d_done_n <= d_done_n + 1;
        s_xd <= s_xm[s_xa[4:0]];
        s_yd <= s_ym[s_ya[4:0]];
        if (s_we) begin
            s_zm[s_za[4:0]] <= s_zd;
            s_wlog[s_we_n[5:0]] <= s_za;
            s_we_n <= s_we_n + 1;
        end
        if (s_done) s_done_n <= s_done_n + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_d(output int n);
        n = 0;
        while (d_busy === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_s(output int n);
        n = 0;
        while (s_busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic fill_d(input logic [31:0] xv, input logic [31:0] yv);
        for (int e = 0; e < 32; e++) begin
            d_xm[e] = xv;
            d_ym[e] = yv;
        end
    endtask

    task automatic check_d_all(input string name, input logic [31:0] exp);
        for (int e = 0; e < 25; e++) begin
            checks++;
            if (d_zm[e] !== exp) begin
                failures++;
                $display("FAIL %s z[%0d] got=%h exp=%h", name, e, d_zm[e], exp);
            end
        end
    endtask

    task automatic run_d(input string name, input int exp_cycles, input logic [31:0] exp);
        int n, w0, dn0;
        w0 = d_we_n;
        dn0 = d_done_n;
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        wait_d(n);
        checks++;
        if (n !== exp_cycles) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", name, n, exp_cycles);
        end
        checks++;
        if (d_done !== 1'b1) begin
            failures++;
            $display("FAIL %s done_after_busy got=%b exp=1", name, d_done);
        end
        tick();
        checks++;
        if (d_done_n - dn0 !== 1 || d_we_n - w0 !== 25) begin
            failures++;
            $display("FAIL %s pulses done=%0d we=%0d exp done=1 we=25", name,
                     d_done_n - dn0, d_we_n - w0);
        end
        check_d_all(name, exp);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        d_start = 1'b0;
        s_start = 1'b0;
        tick();
        tick();
        checks++;
        if ({d_busy, d_done, d_we, s_busy, s_done, s_we} !== 6'b0 ||
            d_xa !== 0 || d_ya !== 0 || d_za !== 0 || d_zd !== 0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b done=%b we=%b xa=%h ya=%h za=%h zd=%h exp all 0",
                     d_busy, d_done, d_we, d_xa, d_ya, d_za, d_zd);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_identity;
        logic [31:0] exp_z [4];
        int n, w0, dn0;
        exp_z = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
        for (int e = 0; e < 4; e++) s_xm[e] = exp_z[e];
        s_ym[0] = 32'h0001_0000; s_ym[1] = 32'h0; s_ym[2] = 32'h0; s_ym[3] = 32'h0001_0000;
        w0 = s_we_n;
        dn0 = s_done_n;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        checks++;
        if (s_busy !== 1'b1) begin
            failures++;
            $display("FAIL identity_busy_after_start got=%b exp=1", s_busy);
        end
        wait_s(n);
        checks++;
        if (n !== 20) begin
            failures++;
            $display("FAIL identity_busy_cycles got=%0d exp=20", n);
        end
        checks++;
        if (s_done !== 1'b1) begin
            failures++;
            $display("FAIL identity_done got=%b exp=1", s_done);
        end
        tick();
        checks++;
        if (s_done !== 1'b0 || s_done_n - dn0 !== 1 || s_we_n - w0 !== 4) begin
            failures++;
            $display("FAIL identity_pulses done=%b done_n=%0d we_n=%0d exp 0/1/4",
                     s_done, s_done_n - dn0, s_we_n - w0);
        end
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (s_wlog[(w0 + e) % 64] !== 32'(e) || s_zm[e] !== exp_z[e]) begin
                failures++;
                $display("FAIL identity_z%0d addr=%0d data=%h exp addr=%0d data=%h",
                         e, s_wlog[(w0 + e) % 64], s_zm[e], e, exp_z[e]);
            end
        end
    endtask

    task automatic test_default;
        fill_d(32'h0001_0000, 32'h0001_0000);
        run_d("default_ones", 275, 32'h0005_0000);
    endtask

    task automatic test_saturation;
        fill_d(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_d("sat_max", 275, 32'h7FFF_FFFF);
        fill_d(32'h8000_0000, 32'h7FFF_FFFF);
        run_d("sat_min", 275, 32'h8000_0000);
    endtask

    task automatic test_start_ignored;
        int n, w0;
        fill_d(32'h0001_0000, 32'h0001_0000);
        w0 = d_we_n;
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        n = 0;
        while (d_busy === 1'b1 && n < 2000) begin
            n++;
            d_start = (n == 3 || n == 10);
            tick();
        end
        d_start = 1'b0;
        checks++;
        if (n !== 275) begin
            failures++;
            $display("FAIL start_ignored_cycles got=%0d exp=275", n);
        end
        tick();
        checks++;
        if (d_busy !== 1'b0 || d_we_n - w0 !== 25) begin
            failures++;
            $display("FAIL start_ignored_rerun busy=%b we=%0d exp busy=0 we=25", d_busy, d_we_n - w0);
        end
        check_d_all("start_ignored", 32'h0005_0000);
    endtask

    task automatic test_reset_mid;
        int w0;
        fill_d(32'h0002_0000, 32'h0002_0000);
        w0 = d_we_n;
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (d_busy !== 1'b0 || d_we !== 1'b0 || d_done !== 1'b0 ||
            d_xa !== 0 || d_ya !== 0 || d_za !== 0) begin
            failures++;
            $display("FAIL reset_mid busy=%b we=%b done=%b xa=%h ya=%h za=%h exp all 0",
                     d_busy, d_we, d_done, d_xa, d_ya, d_za);
        end
        tick();
        tick();
        checks++;
        if (d_busy !== 1'b0 || d_we_n - w0 !== 0) begin
            failures++;
            $display("FAIL reset_mid_quiet busy=%b writes=%0d exp 0/0", d_busy, d_we_n - w0);
        end
        run_d("after_reset", 275, 32'h0014_0000);
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp1 [4];
        logic [31:0] exp2 [4];
        int n;
        exp1 = '{32'h0002_0000, 32'h0001_0000, 32'h0004_0000, 32'h0003_0000};
        exp2 = '{32'hFFFF_8000, 32'hFFFF_0000, 32'hFFFE_8000, 32'hFFFE_0000};
        s_xm[0] = 32'h0001_0000; s_xm[1] = 32'h0002_0000;
        s_xm[2] = 32'h0003_0000; s_xm[3] = 32'h0004_0000;
        s_ym[0] = 32'h0; s_ym[1] = 32'h0001_0000; s_ym[2] = 32'h0001_0000; s_ym[3] = 32'h0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        wait_s(n);
        checks++;
        if (s_done !== 1'b1 || n !== 20) begin
            failures++;
            $display("FAIL b2b_first done=%b cycles=%0d exp 1/20", s_done, n);
        end
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (s_zm[e] !== exp1[e]) begin
                failures++;
                $display("FAIL b2b_first_z%0d got=%h exp=%h", e, s_zm[e], exp1[e]);
            end
        end
        s_ym[0] = 32'hFFFF_8000; s_ym[1] = 32'h0; s_ym[2] = 32'h0; s_ym[3] = 32'hFFFF_8000;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        checks++;
        if (s_busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy_after_done_start got=%b exp=1", s_busy);
        end
        wait_s(n);
        checks++;
        if (n !== 20 || s_done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second cycles=%0d done=%b exp 20/1", n, s_done);
        end
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (s_zm[e] !== exp2[e]) begin
                failures++;
                $display("FAIL b2b_second_z%0d got=%h exp=%h", e, s_zm[e], exp2[e]);
            end
        end
        tick();
    endtask

    initial begin
        for (int e = 0; e < 32; e++) begin
            s_xm[e] = '0;
            s_ym[e] = '0;
        end
        fill_d(32'h0, 32'h0);
        test_reset();
        test_identity();
        test_default();
        test_saturation();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
